student_iic_target: RTL

- I2C target (responder) for the codec-control bus: the far end of the I2C write sequences issued by the audio-init master.
- Decodes START, 7-bit address, 16-bit register subaddress, and write/read data bytes with auto-increment.
- Holds a local codec-style register file for codec emulation in simulation and on FPGA loopback, and for system-level checking of the init sequence.
- Flags every committed write on a strobe port.

---
 rtl/student_iic_target.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/student_iic_target.sv
// student_iic_target: I2C target with 16-bit subaddress, auto-increment and a codec-style register file.
//   clk_i/rst_i             system clock, synchronous active-high reset
//   scl_i/sda_i             asynchronous bus levels; sda_oe pulls SDA low
//   wr_valid_o/addr/data    one-cycle strobe per received data byte
//   dbg_idx_i/dbg_data_o    combinational register-file peek
//   busy_o                  high from an addressed START until STOP
module student_iic_target #(
  parameter logic [6:0]  IIC_ADDR = 7'h3B,
  parameter logic [15:0] REG_BASE = 16'h4000,
  parameter int          NUM_REGS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_valid_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  input  logic [7:0]  dbg_idx_i,
  output logic [7:0]  dbg_data_o,
  output logic        busy_o
);
  localparam int IW = $clog2(NUM_REGS);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, SUB_HI, SUB_LO, WDATA, RDATA, RACK, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sr, sr_n, wd_n, byte_in, rd_byte;
  logic [15:0] ptr, ptr_n, wa_n, off;
  logic oe_n, busy_n, wv_n, we, scl, sda, rise, fall, start, stop, in_win;
  logic [7:0] regs [NUM_REGS];
  // bit 1 is the synchronized level, bit 2 its one-cycle history
  assign scl = scl_q[1];
  assign sda = sda_q[1];
  assign rise = scl & ~scl_q[2];
  assign fall = ~scl & scl_q[2];
  assign start = scl & scl_q[2] & sda_q[2] & ~sda;
  assign stop = scl & scl_q[2] & ~sda_q[2] & sda;
  assign byte_in = {sr[6:0], sda};
  assign off = ptr - REG_BASE;
  assign in_win = {16'd0, off} < 32'(NUM_REGS);
  assign rd_byte = in_win ? regs[off[IW-1:0]] : 8'h00;
  assign dbg_data_o = regs[dbg_idx_i[IW-1:0]];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    ptr_n = ptr;
    oe_n = sda_oe;
    busy_n = busy_o;
    wv_n = 1'b0;
    wa_n = wr_addr_o;
    wd_n = wr_data_o;
    we = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      oe_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (rise) begin
          sr_n = byte_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            state_n = (byte_in[7:1] == IIC_ADDR) ? ADDR_ACK : WAIT_STOP;
            busy_n = busy_o | (byte_in[7:1] == IIC_ADDR);
          end
        end
        // first fall pulls SDA, second fall (after the 9th clock) releases and moves on
        ADDR_ACK: if (fall) begin
          oe_n = ~sda_oe;
          if (sda_oe) begin
            cnt_n = '0;
            state_n = sr[0] ? RDATA : SUB_HI;
            if (sr[0]) begin
              sr_n = rd_byte;
              oe_n = ~rd_byte[7];
              ptr_n = ptr + 16'd1;
            end
          end
        end
        SUB_HI, SUB_LO, WDATA: if (cnt != 4'd8) begin
          if (rise) begin
            sr_n = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (state == SUB_HI) ptr_n[15:8] = byte_in;
              else if (state == SUB_LO) ptr_n[7:0] = byte_in;
              else begin
                wv_n = 1'b1;
                wa_n = ptr;
                wd_n = byte_in;
                we = in_win;
                ptr_n = ptr + 16'd1;
              end
            end
          end
        end else if (fall) begin
          oe_n = ~sda_oe;
          if (sda_oe) begin
            cnt_n = '0;
            state_n = (state == SUB_HI) ? SUB_LO : WDATA;
          end
        end
        RDATA: if (rise) cnt_n = cnt + 4'd1;
        else if (fall && cnt != 4'd0) begin
          if (cnt == 4'd8) begin
            oe_n = 1'b0;
            cnt_n = '0;
            state_n = RACK;
          end else begin
            sr_n = {sr[6:0], 1'b0};
            oe_n = ~sr[6];
          end
        end
        // cnt = 9 marks "master ACKed, next byte loaded, drive it on the next fall"
        RACK: if (rise) begin
          if (sda) state_n = WAIT_STOP;
          else begin
            sr_n = rd_byte;
            ptr_n = ptr + 16'd1;
            cnt_n = 4'd9;
          end
        end else if (fall && cnt == 4'd9) begin
          state_n = RDATA;
          cnt_n = '0;
          oe_n = ~sr[7];
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      ptr <= '0;
      sda_oe <= 1'b0;
      busy_o <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      ptr <= ptr_n;
      sda_oe <= oe_n;
      busy_o <= busy_n;
      wr_valid_o <= wv_n;
      wr_addr_o <= wa_n;
      wr_data_o <= wd_n;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) regs <= '{default: 8'h00};
    else if (we) regs[off[IW-1:0]] <= byte_in;
  end
endmodule
